stateful_array_atom: RTL and testbench

- Parametrised successor of the single-register stateful ALU atom.
- Holds DEPTH independent WIDTH-bit state entries, selected per packet by an index field, so one atom serves a whole flow or register table.
- Uses the same predicated read-modify-write datapath as the single-register atom, plus a valid/ready handshake, a post-reset clear sweep and optional saturating update.
- Sits in a pipeline stage between packet-field extraction and the next stateless stage.

---
 rtl/atom_pkg.sv | 52 +++++
 rtl/atom_alu_datapath.sv | 60 ++++++
 rtl/stateful_array_atom.sv | 168 ++++++++++++++++
 tb/tb_stateful_array_atom.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_pkg.sv
// Shared definitions for the stateful array atom.
// The operand helpers work at ATOM_MAX_W bits. Callers zero-extend WIDTH-bit operands and
// truncate results back to WIDTH. Unsigned compares and modular add/sub give the same answer
// at that width as they would at WIDTH bits.
package atom_pkg;

   localparam int unsigned ATOM_MAX_W = 64;
   typedef logic [ATOM_MAX_W-1:0] word_t;

   localparam logic [1:0] REL_NE = 2'd0;
   localparam logic [1:0] REL_LT = 2'd1;
   localparam logic [1:0] REL_GT = 2'd2;
   localparam logic [1:0] REL_EQ = 2'd3;

   localparam logic ARITH_SUB = 1'b0;
   localparam logic ARITH_ADD = 1'b1;

   typedef enum logic {CLEAR, RUN} atom_state_e;

   // State-or-zero select: 0 = state, 1 = zero.
   function automatic word_t mux2(input word_t a, input logic sel);
      return sel ? '0 : a;
   endfunction

   // Operand select: 0 = pkt_1, 1 = pkt_2, 2 and 3 = constant.
   function automatic word_t mux3(input word_t p1, input word_t p2, input word_t c,
                                  input logic [1:0] sel);
      word_t r;
      case (sel)
         2'd0:    r = p1;
         2'd1:    r = p2;
         default: r = c;
      endcase
      return r;
   endfunction

   function automatic logic rel_op(input word_t a, input word_t b, input logic [1:0] op);
      logic r;
      case (op)
         REL_NE:  r = (a != b);
         REL_LT:  r = (a < b);
         REL_GT:  r = (a > b);
         default: r = (a == b);
      endcase
      return r;
   endfunction

   function automatic word_t arith_op(input word_t a, input word_t b, input logic op);
      return (op == ARITH_ADD) ? (a + b) : (a - b);
   endfunction

endpackage

// File: rtl/atom_alu_datapath.sv
// Predicated read-modify-write datapath, purely combinational.
// Ports: s_i current entry value; pkt_*_i packet operands; cons_*_i constants; sel_*_i
// operand selects; rel_opcode_i compare op; arith_opcode*_i add/sub; write_o updated value.
// The intermediate term wraps modulo 2^WIDTH; only the final base + term may saturate.
module atom_alu_datapath
   import atom_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter bit          SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] pkt_1_i,
   input  logic [WIDTH-1:0] pkt_2_i,
   input  logic [WIDTH-1:0] cons_1_i,
   input  logic [WIDTH-1:0] cons_2_i,
   input  logic [WIDTH-1:0] cons_3_i,
   input  logic [WIDTH-1:0] cons_4_i,
   input  logic [WIDTH-1:0] cons_5_i,
   input  logic             sel_1_i,
   input  logic [1:0]       sel_2_i,
   input  logic             sel_3_i,
   input  logic [1:0]       sel_4_i,
   input  logic             sel_5_i,
   input  logic [1:0]       sel_6_i,
   input  logic [1:0]       sel_7_i,
   input  logic [1:0]       sel_8_i,
   input  logic [1:0]       rel_opcode_i,
   input  logic             arith_opcode1_i,
   input  logic             arith_opcode2_i,
   output logic [WIDTH-1:0] write_o
);

   word_t s_w, p1_w, p2_w;
   logic             pred;
   logic [WIDTH-1:0] base, term;
   logic [WIDTH:0]   sum;

   assign s_w  = word_t'(s_i);
   assign p1_w = word_t'(pkt_1_i);
   assign p2_w = word_t'(pkt_2_i);

   always_comb begin
      pred = rel_op(mux2(s_w, sel_1_i), mux3(p1_w, p2_w, word_t'(cons_1_i), sel_2_i),
                    rel_opcode_i);
      if (pred) begin
         base = WIDTH'(mux2(s_w, sel_3_i));
         term = WIDTH'(arith_op(mux3(p1_w, p2_w, word_t'(cons_2_i), sel_4_i),
                                mux3(p1_w, p2_w, word_t'(cons_4_i), sel_7_i),
                                arith_opcode1_i));
      end else begin
         base = WIDTH'(mux2(s_w, sel_5_i));
         term = WIDTH'(arith_op(mux3(p1_w, p2_w, word_t'(cons_3_i), sel_6_i),
                                mux3(p1_w, p2_w, word_t'(cons_5_i), sel_8_i),
                                arith_opcode2_i));
      end
      sum     = {1'b0, base} + {1'b0, term};
      write_o = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
   end

endmodule

// File: rtl/stateful_array_atom.sv
// Stateful ALU atom over DEPTH independent state entries selected by i__idx.
// Ports: clk/rst (sync, active-high); i__valid/i__ready handshake; i__idx entry selector;
// i__pkt_*, i__cons_*, i__sel_*, opcodes configure the update; o__valid/o__idx/o__read/
// o__write report the entry before and after the update, one cycle after accept.
// After reset a DEPTH-cycle sweep zeroes every entry while i__ready is held low.
module stateful_array_atom
   import atom_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned IDX_W    = $clog2(DEPTH),
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i__valid,
   output logic             i__ready,
   input  logic [IDX_W-1:0] i__idx,
   input  logic [WIDTH-1:0] i__pkt_1,
   input  logic [WIDTH-1:0] i__pkt_2,
   input  logic [WIDTH-1:0] i__cons_1,
   input  logic [WIDTH-1:0] i__cons_2,
   input  logic [WIDTH-1:0] i__cons_3,
   input  logic [WIDTH-1:0] i__cons_4,
   input  logic [WIDTH-1:0] i__cons_5,
   input  logic             i__sel_1,
   input  logic [1:0]       i__sel_2,
   input  logic             i__sel_3,
   input  logic [1:0]       i__sel_4,
   input  logic             i__sel_5,
   input  logic [1:0]       i__sel_6,
   input  logic [1:0]       i__sel_7,
   input  logic [1:0]       i__sel_8,
   input  logic [1:0]       i__rel_opcode,
   input  logic             i__arith_opcode1,
   input  logic             i__arith_opcode2,
   output logic             o__valid,
   output logic [IDX_W-1:0] o__idx,
   output logic [WIDTH-1:0] o__read,
   output logic [WIDTH-1:0] o__write
);

   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

   atom_state_e      fsm_q;
   logic [IDX_W-1:0] clr_cnt_q;
   logic             ready_q;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Stage-1 capture registers
   logic             s1_valid_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] pkt_1_q, pkt_2_q;
   logic [WIDTH-1:0] cons_1_q, cons_2_q, cons_3_q, cons_4_q, cons_5_q;
   logic             sel_1_q, sel_3_q, sel_5_q;
   logic [1:0]       sel_2_q, sel_4_q, sel_6_q, sel_7_q, sel_8_q;
   logic [1:0]       rel_opcode_q;
   logic             arith_opcode1_q, arith_opcode2_q;

   logic             accept;
   logic             idx_in_range;
   logic             wr_en;
   logic [WIDTH-1:0] s_val;
   logic [WIDTH-1:0] w_val;

   assign accept   = i__valid && ready_q;
   assign i__ready = ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (fsm_q)
            CLEAR: begin
               clr_cnt_q <= clr_cnt_q + IDX_W'(1);
               if (clr_cnt_q == CNT_LAST) begin
                  fsm_q   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: ;
            default: begin
               fsm_q   <= CLEAR;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= accept;
      end
      if (accept) begin
         idx_q           <= i__idx;
         pkt_1_q         <= i__pkt_1;
         pkt_2_q         <= i__pkt_2;
         cons_1_q        <= i__cons_1;
         cons_2_q        <= i__cons_2;
         cons_3_q        <= i__cons_3;
         cons_4_q        <= i__cons_4;
         cons_5_q        <= i__cons_5;
         sel_1_q         <= i__sel_1;
         sel_2_q         <= i__sel_2;
         sel_3_q         <= i__sel_3;
         sel_4_q         <= i__sel_4;
         sel_5_q         <= i__sel_5;
         sel_6_q         <= i__sel_6;
         sel_7_q         <= i__sel_7;
         sel_8_q         <= i__sel_8;
         rel_opcode_q    <= i__rel_opcode;
         arith_opcode1_q <= i__arith_opcode1;
         arith_opcode2_q <= i__arith_opcode2;
      end
   end

   // Only matters for non-power-of-2 DEPTH, where the index port can exceed the array.
   assign idx_in_range = ({1'b0, idx_q} < (IDX_W + 1)'(DEPTH));
   assign s_val        = idx_in_range ? mem_q[idx_q] : '0;
   // Reset drops the in-flight packet, so its write-back is suppressed in the reset cycle.
   assign wr_en        = s1_valid_q && idx_in_range && !rst;

   atom_alu_datapath #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_datapath (
      .s_i             (s_val),
      .pkt_1_i         (pkt_1_q),
      .pkt_2_i         (pkt_2_q),
      .cons_1_i        (cons_1_q),
      .cons_2_i        (cons_2_q),
      .cons_3_i        (cons_3_q),
      .cons_4_i        (cons_4_q),
      .cons_5_i        (cons_5_q),
      .sel_1_i         (sel_1_q),
      .sel_2_i         (sel_2_q),
      .sel_3_i         (sel_3_q),
      .sel_4_i         (sel_4_q),
      .sel_5_i         (sel_5_q),
      .sel_6_i         (sel_6_q),
      .sel_7_i         (sel_7_q),
      .sel_8_i         (sel_8_q),
      .rel_opcode_i    (rel_opcode_q),
      .arith_opcode1_i (arith_opcode1_q),
      .arith_opcode2_i (arith_opcode2_q),
      .write_o         (w_val)
   );

   // The sweep and packet write-back never overlap: s1_valid_q is low throughout CLEAR.
   always_ff @(posedge clk) begin
      if (fsm_q == CLEAR) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (wr_en) begin
         mem_q[idx_q] <= w_val;
      end
   end

   assign o__valid = s1_valid_q;
   assign o__idx   = s1_valid_q ? idx_q : '0;
   assign o__read  = s1_valid_q ? s_val : '0;
   assign o__write = s1_valid_q ? w_val : '0;

endmodule

// File: tb/tb_stateful_array_atom.sv
// Bench for stateful_array_atom: drives a wrapping (SATURATE=0) and a saturating (SATURATE=1)
// instance with the same packets. Expected results come from a behavioural model and are
// queued at drive time, then popped when o__valid shows up.
module tb_stateful_array_atom;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i__valid = 1'b0;
   logic [3:0]  i__idx = '0;
   logic [31:0] i__pkt_1 = '0, i__pkt_2 = '0;
   logic [31:0] i__cons_1 = '0, i__cons_2 = '0, i__cons_3 = '0, i__cons_4 = '0, i__cons_5 = '0;
   logic        i__sel_1 = 1'b0, i__sel_3 = 1'b0, i__sel_5 = 1'b0;
   logic [1:0]  i__sel_2 = '0, i__sel_4 = '0, i__sel_6 = '0, i__sel_7 = '0, i__sel_8 = '0;
   logic [1:0]  i__rel_opcode = '0;
   logic        i__arith_opcode1 = 1'b0, i__arith_opcode2 = 1'b0;

   logic        d0_ready, d0_valid, d1_ready, d1_valid;
   logic [3:0]  d0_idx, d1_idx;
   logic [31:0] d0_read, d0_write, d1_read, d1_write;

   always #5 clk = ~clk;

   stateful_array_atom #(.WIDTH(32), .DEPTH(16), .SATURATE(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .i__valid(i__valid), .i__ready(d0_ready), .i__idx(i__idx),
      .i__pkt_1(i__pkt_1), .i__pkt_2(i__pkt_2), .i__cons_1(i__cons_1), .i__cons_2(i__cons_2),
      .i__cons_3(i__cons_3), .i__cons_4(i__cons_4), .i__cons_5(i__cons_5),
      .i__sel_1(i__sel_1), .i__sel_2(i__sel_2), .i__sel_3(i__sel_3), .i__sel_4(i__sel_4),
      .i__sel_5(i__sel_5), .i__sel_6(i__sel_6), .i__sel_7(i__sel_7), .i__sel_8(i__sel_8),
      .i__rel_opcode(i__rel_opcode), .i__arith_opcode1(i__arith_opcode1),
      .i__arith_opcode2(i__arith_opcode2), .o__valid(d0_valid), .o__idx(d0_idx),
      .o__read(d0_read), .o__write(d0_write));

   stateful_array_atom #(.WIDTH(32), .DEPTH(16), .SATURATE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .i__valid(i__valid), .i__ready(d1_ready), .i__idx(i__idx),
      .i__pkt_1(i__pkt_1), .i__pkt_2(i__pkt_2), .i__cons_1(i__cons_1), .i__cons_2(i__cons_2),
      .i__cons_3(i__cons_3), .i__cons_4(i__cons_4), .i__cons_5(i__cons_5),
      .i__sel_1(i__sel_1), .i__sel_2(i__sel_2), .i__sel_3(i__sel_3), .i__sel_4(i__sel_4),
      .i__sel_5(i__sel_5), .i__sel_6(i__sel_6), .i__sel_7(i__sel_7), .i__sel_8(i__sel_8),
      .i__rel_opcode(i__rel_opcode), .i__arith_opcode1(i__arith_opcode1),
      .i__arith_opcode2(i__arith_opcode2), .o__valid(d1_valid), .o__idx(d1_idx),
      .o__read(d1_read), .o__write(d1_write));

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en   = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] rd0, wr0, rd1, wr1;
   } exp_t;
   exp_t sb[$];

   logic [31:0] m0 [16];
   logic [31:0] m1 [16];

   function automatic logic [31:0] opnd(input logic [1:0] sel, input logic [31:0] c);
      if (sel == 2'd0) return i__pkt_1;
      if (sel == 2'd1) return i__pkt_2;
      return c;
   endfunction

   function automatic logic [31:0] model(input logic [31:0] s, input bit sat);
      logic [31:0] a, b, base, x, y, t;
      bit          p;
      longint      sum;
      a = i__sel_1 ? 32'd0 : s;
      b = opnd(i__sel_2, i__cons_1);
      case (i__rel_opcode)
         2'd0:    p = (a != b);
         2'd1:    p = (a < b);
         2'd2:    p = (a > b);
         default: p = (a == b);
      endcase
      if (p) begin
         base = i__sel_3 ? 32'd0 : s;
         x = opnd(i__sel_4, i__cons_2);
         y = opnd(i__sel_7, i__cons_4);
         t = i__arith_opcode1 ? x + y : x - y;
      end else begin
         base = i__sel_5 ? 32'd0 : s;
         x = opnd(i__sel_6, i__cons_3);
         y = opnd(i__sel_8, i__cons_5);
         t = i__arith_opcode2 ? x + y : x - y;
      end
      sum = longint'(base) + longint'(t);
      if (sat && sum > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return sum[31:0];
   endfunction

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("valid_match", d1_valid, d0_valid);
         if (d0_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_valid", d0_valid, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("idx", d0_idx, e.idx);
               check_eq("read_wrap", d0_read, e.rd0);
               check_eq("write_wrap", d0_write, e.wr0);
               check_eq("read_sat", d1_read, e.rd1);
               check_eq("write_sat", d1_write, e.wr1);
            end
         end else begin
            check_eq("idle_zero", {d0_idx, d0_read, d0_write}, '0);
         end
      end
   end

   task automatic send(input logic [3:0] idx);
      exp_t e;
      check_eq("ready_at_send", {d0_ready, d1_ready}, 2'b11);
      i__idx   = idx;
      i__valid = 1'b1;
      e.idx = idx;
      e.rd0 = m0[idx];
      e.wr0 = model(m0[idx], 1'b0);
      e.rd1 = m1[idx];
      e.wr1 = model(m1[idx], 1'b1);
      m0[idx] = e.wr0;
      m1[idx] = e.wr1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      i__valid = 1'b0;
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check_eq("rst_valid", {d0_valid, d1_valid}, 2'b00);
      check_eq("rst_ready", {d0_ready, d1_ready}, 2'b00);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      n = 0;
      while (d0_ready !== 1'b1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("sweep_cycles", n, 16);
      check_eq("sweep_ready_sat", d1_ready, 1'b1);
   endtask

   // Predicate forced true, state + cons_2 + cons_4 (or cons_2 alone when load is set).
   task automatic cfg_true(input logic load, input logic [31:0] k);
      i__sel_1 = 1'b1; i__rel_opcode = 2'd3; i__sel_2 = 2'd2; i__cons_1 = '0;
      i__sel_3 = load; i__sel_4 = 2'd2; i__cons_2 = k; i__sel_7 = 2'd2; i__cons_4 = '0;
      i__arith_opcode1 = 1'b1;
      i__sel_5 = 1'b0; i__sel_6 = 2'd2; i__sel_8 = 2'd2; i__cons_3 = '0; i__cons_5 = '0;
      i__arith_opcode2 = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // First packet after the sweep reads zero
      cfg_true(1'b0, 32'd1);
      send(4'd9);

      // Counter on idx 3, back to back
      repeat (5) send(4'd3);

      // Index isolation, then an untouched index
      for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 4'd2 : 4'd5);
      send(4'd0);
      idle(2);

      // Predicate false path: state[1]=10, 10 > 20 false, 10 + (20 - 3)
      cfg_true(1'b1, 32'd10);
      send(4'd1);
      i__sel_1 = 1'b0; i__rel_opcode = 2'd2; i__sel_2 = 2'd0; i__pkt_1 = 32'd20;
      i__sel_5 = 1'b0; i__sel_6 = 2'd0; i__sel_8 = 2'd1; i__pkt_2 = 32'd3;
      i__arith_opcode2 = 1'b0;
      send(4'd1);
      idle(2);

      // Saturation on the final add
      i__pkt_1 = '0; i__pkt_2 = '0;
      cfg_true(1'b1, 32'hFFFF_FFF0);
      send(4'd4);
      cfg_true(1'b0, 32'h20);
      send(4'd4);

      // Term underflow wraps, final add still saturates: 5 + (0 - 1)
      cfg_true(1'b1, 32'd5);
      send(4'd6);
      cfg_true(1'b0, 32'd0);
      i__cons_4 = 32'd1; i__arith_opcode1 = 1'b0;
      send(4'd6);
      idle(2);

      // Mixed random traffic
      for (int i = 0; i < 40; i++) begin
         i__pkt_1 = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 40)
                                              : $urandom_range(0, 60);
         i__pkt_2 = $urandom;
         i__cons_1 = $urandom_range(0, 50); i__cons_2 = $urandom;
         i__cons_3 = $urandom_range(0, 50); i__cons_4 = $urandom; i__cons_5 = $urandom;
         i__sel_1 = 1'($urandom); i__sel_3 = 1'($urandom); i__sel_5 = 1'($urandom);
         i__sel_2 = 2'($urandom); i__sel_4 = 2'($urandom); i__sel_6 = 2'($urandom);
         i__sel_7 = 2'($urandom); i__sel_8 = 2'($urandom);
         i__rel_opcode = 2'($urandom);
         i__arith_opcode1 = 1'($urandom); i__arith_opcode2 = 1'($urandom);
         send(4'($urandom_range(0, 15)));
      end
      idle(2);

      // Reset while an idx-7 update is on the outputs
      i__pkt_1 = '0; i__pkt_2 = '0;
      cfg_true(1'b1, 32'd50);
      send(4'd7);
      cfg_true(1'b0, 32'd1);
      send(4'd7);
      do_reset();
      send(4'd7);
      idle(3);

      check_eq("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
